// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver state encoding and framing constants
// common to the receiver, the transmitter and the baud tick generator.
package usart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DIV_WIDTH  = 12;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/usart_rx_if.sv
// Host-side register handshake of the USART receiver: the received byte,
// its status flags and the host acknowledge.
interface usart_rx_if;
  import usart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 available;
  logic                 error;
  logic                 acknowledge;

  // Receiver side presents the byte and flags, host side acknowledges
  modport slave (
    output data_out,
    output available,
    output error,
    input  acknowledge
  );

  modport master (
    input  data_out,
    input  available,
    input  error,
    output acknowledge
  );

endinterface

// File: rtl/usart_baud_tick.sv
// Oversample prescaler: counts 0..divisor and emits a one-clock tick on the
// wrap. Held at zero while clear is asserted so the tick phase can be
// aligned to an external event such as a start edge.
module usart_baud_tick
  import usart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count_q, count_d;

  // The >= keeps the counter from running away if the divisor shrinks
  assign tick_o = !clear_i && (count_q >= divisor_i);

  // Next count: hold at zero when cleared, restart on every tick
  always_comb begin
    count_d = count_q;
    if (clear_i || tick_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usart_rx.sv
// USART receiver: 16x oversampled 8N1 deframer with a host handshake.
// The byte is held with an available flag until acknowledged; framing and
// overrun problems raise a sticky error flag.
module usart_rx
  import usart_pkg::*;
(
  input  logic                 comm_clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] clocks_per_bit,
  input  logic                 rx_pin,
  usart_rx_if.slave            host
);

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rxMeta_q, rxs_q;
  rx_state_e            state_q, state_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [BIT_W-1:0]     bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dataOut_q, dataOut_d;
  logic                 avail_q, avail_d;
  logic                 err_q, err_d;
  logic                 baudTick;
  logic                 frameDone;
  logic                 framingErr;

  // Prescaler is parked in IDLE so sampling phase starts at the start edge
  usart_baud_tick u_baud_tick (
    .clk       (comm_clock),
    .rst_n     (reset),
    .clear_i   (state_q == IDLE),
    .divisor_i (clocks_per_bit),
    .tick_o    (baudTick)
  );

  // Two-flop synchronizer; resets to the idle line level to avoid a false start
  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= rx_pin;
      rxs_q    <= rxMeta_q;
    end
  end

  // Frame sequencing: start validation, mid-bit data sampling, stop check
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    frameDone  = 1'b0;
    framingErr = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d   = '0;
        bitIdx_d = '0;
        if (!rxs_q) begin
          state_d = START;
        end
      end
      START: begin
        if (baudTick) begin
          if (tcnt_q == TCNT_MID) begin
            tcnt_d   = '0;
            bitIdx_d = '0;
            state_d  = rxs_q ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      DATA: begin
        if (baudTick) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_LAST) begin
            shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
            if (bitIdx_q == BIT_LAST) begin
              bitIdx_d = '0;
              state_d  = STOP;
            end else begin
              bitIdx_d = bitIdx_q + BIT_W'(1);
            end
          end
        end
      end
      STOP: begin
        if (baudTick) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_LAST) begin
            frameDone  = 1'b1;
            framingErr = !rxs_q;
            state_d    = rxs_q ? IDLE : WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Host flags: a completing frame beats a simultaneous acknowledge
  always_comb begin
    dataOut_d = dataOut_q;
    avail_d   = avail_q;
    err_d     = err_q;
    if (frameDone) begin
      dataOut_d = shift_q;
      avail_d   = 1'b1;
      err_d     = (err_q && !host.acknowledge)
                | (avail_q && !host.acknowledge)
                | framingErr;
    end else if (host.acknowledge) begin
      avail_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      dataOut_q <= '0;
      avail_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      dataOut_q <= dataOut_d;
      avail_q   <= avail_d;
      err_q     <= err_d;
    end
  end

  assign host.data_out  = dataOut_q;
  assign host.available = avail_q;
  assign host.error     = err_q;

endmodule

// File: tb/tb_usart_rx.sv
// Testbench for usart_rx: directed frames from the test plan followed by
// randomized frames, glitches, breaks, rate changes and acknowledges.
// Outputs are compared every cycle against a timestamp-based line model.
module tb_usart_rx;
  import usart_pkg::*;

  logic                 comm_clock = 1'b0;
  logic                 reset = 1'b0;
  logic [DIV_WIDTH-1:0] clocks_per_bit = '0;
  logic                 rx_pin = 1'b1;
  logic                 ackDir = 1'b0;
  logic                 ackRnd = 1'b0;
  logic                 ackRandomOn = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  usart_rx_if host ();
  assign host.acknowledge = ackDir | ackRnd;

  usart_rx dut (
    .comm_clock     (comm_clock),
    .reset          (reset),
    .clocks_per_bit (clocks_per_bit),
    .rx_pin         (rx_pin),
    .host           (host)
  );

  always #5 comm_clock = ~comm_clock;

  // Reference model: line history delayed by the synchronizer, then sample
  // points taken directly as multiples of D from the detected start edge
  logic [7:0] mData = 8'h00;
  logic       mAvail = 1'b0;
  logic       mErr = 1'b0;
  int         mMode = 0;
  int         mAge = 0;
  logic [7:0] mBits = 8'h00;
  logic       mL1 = 1'b1;
  logic       mL2 = 1'b1;

  always @(posedge comm_clock or negedge reset) begin : refModel
    int   d;
    int   rel;
    logic rs;
    logic done;
    logic stopV;
    logic ackS;
    if (!reset) begin
      mData  = 8'h00;
      mAvail = 1'b0;
      mErr   = 1'b0;
      mMode  = 0;
      mAge   = 0;
      mBits  = 8'h00;
      mL1    = 1'b1;
      mL2    = 1'b1;
    end else begin
      d     = int'(clocks_per_bit) + 1;
      rs    = mL2;
      ackS  = host.acknowledge;
      done  = 1'b0;
      stopV = 1'b1;
      case (mMode)
        0: begin
          if (!rs) begin
            mMode = 1;
            mAge  = 0;
          end
        end
        1: begin
          mAge = mAge + 1;
          if (mAge == 8 * d) begin
            if (rs) mMode = 0;
          end else if (mAge > 8 * d && ((mAge - 8 * d) % (16 * d)) == 0) begin
            rel = (mAge - 8 * d) / (16 * d) - 1;
            if (rel < 8) begin
              mBits[rel[2:0]] = rs;
            end else begin
              done  = 1'b1;
              stopV = rs;
              mMode = rs ? 0 : 2;
            end
          end
        end
        default: begin
          if (rs) mMode = 0;
        end
      endcase
      if (done) begin
        mErr   = (mErr && !ackS) || (mAvail && !ackS) || !stopV;
        mAvail = 1'b1;
        mData  = mBits;
      end else if (ackS) begin
        mAvail = 1'b0;
        mErr   = 1'b0;
      end
      mL2 = mL1;
      mL1 = rx_pin;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge
  always @(negedge comm_clock) begin
    nChecks++;
    if (host.data_out !== mData || host.available !== mAvail || host.error !== mErr) begin
      nFails++;
      $display("[TB] FAIL cycleCompare t=%0t: got data=%h avail=%b err=%b, required data=%h avail=%b err=%b",
               $time, host.data_out, host.available, host.error, mData, mAvail, mErr);
    end
  end

  // Random acknowledge pulses, only during the randomized phase
  initial begin
    forever begin
      @(posedge comm_clock);
      #1;
      ackRnd = ackRandomOn && ($urandom_range(0, 99) == 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge comm_clock);
    #1;
  endtask

  // Drive one 8N1 frame at the current rate; the line is left at the stop level
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    int d;
    d = int'(clocks_per_bit) + 1;
    rx_pin = 1'b0;
    step(16 * d);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      step(16 * d);
    end
    rx_pin = stopBit;
    step(16 * d);
  endtask

  // Hand-computed expectation checked against both DUT and model
  task automatic checkOutput(input string name, input logic [7:0] expData,
                             input logic expAvail, input logic expErr);
    nChecks++;
    if (host.data_out !== expData || host.available !== expAvail || host.error !== expErr) begin
      nFails++;
      $display("[TB] FAIL %s: got data=%h avail=%b err=%b, required data=%h avail=%b err=%b",
               name, host.data_out, host.available, host.error, expData, expAvail, expErr);
    end
    nChecks++;
    if (mData !== expData || mAvail !== expAvail || mErr !== expErr) begin
      nFails++;
      $display("[TB] FAIL %s-model: got data=%h avail=%b err=%b, required data=%h avail=%b err=%b",
               name, mData, mAvail, mErr, expData, expAvail, expErr);
    end
  endtask

  task automatic pulseAck();
    ackDir = 1'b1;
    step(1);
    ackDir = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       stopBit;
    int         d;
    int         g;

    reset = 1'b0;
    rx_pin = 1'b1;
    clocks_per_bit = 12'd1;
    step(5);
    checkOutput("resetState", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step(5);

    applyStimulus(8'h75, 1'b1);
    step(4);
    checkOutput("byte75", 8'h75, 1'b1, 1'b0);
    pulseAck();
    checkOutput("ack75", 8'h75, 1'b0, 1'b0);
    step(20);

    applyStimulus(8'hF5, 1'b0);
    step(400);
    checkOutput("breakHeld", 8'hF5, 1'b1, 1'b1);
    rx_pin = 1'b1;
    step(10);
    pulseAck();
    checkOutput("breakAck", 8'hF5, 1'b0, 1'b0);
    step(20);

    rx_pin = 1'b0;
    step(8);
    rx_pin = 1'b1;
    step(200);
    checkOutput("glitch", 8'hF5, 1'b0, 1'b0);

    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hA3, 1'b1);
    step(4);
    checkOutput("overrun", 8'hA3, 1'b1, 1'b1);

    fork
      applyStimulus(8'h3C, 1'b1);
      begin
        step(2 + 152 * 2);
        ackDir = 1'b1;
        step(1);
        ackDir = 1'b0;
        checkOutput("ackAtDone", 8'h3C, 1'b1, 1'b0);
      end
    join
    step(4);
    pulseAck();
    checkOutput("ackClear", 8'h3C, 1'b0, 1'b0);

    clocks_per_bit = 12'd0;
    step(5);
    applyStimulus(8'h00, 1'b1);
    step(4);
    checkOutput("fast00", 8'h00, 1'b1, 1'b0);

    clocks_per_bit = 12'd1;
    step(5);
    rx_pin = 1'b0;
    step(32);
    rx_pin = 1'b1;
    step(40);
    reset = 1'b0;
    #1;
    checkOutput("midReset", 8'h00, 1'b0, 1'b0);
    rx_pin = 1'b1;
    step(5);
    reset = 1'b1;
    step(5);
    applyStimulus(8'h9A, 1'b1);
    step(4);
    checkOutput("postReset", 8'h9A, 1'b1, 1'b0);
    pulseAck();
    step(10);

    ackRandomOn = 1'b1;
    for (int f = 0; f < 24; f++) begin
      b       = 8'($urandom);
      stopBit = ($urandom_range(0, 5) != 0);
      d       = int'(clocks_per_bit) + 1;
      if ($urandom_range(0, 3) == 0) begin
        g = $urandom_range(1, 7 * d);
        rx_pin = 1'b0;
        step(g);
        rx_pin = 1'b1;
        step(10 * d + 5);
      end
      applyStimulus(b, stopBit);
      if (!stopBit) begin
        step($urandom_range(1, 30));
        rx_pin = 1'b1;
        step($urandom_range(4, 20));
      end else begin
        step($urandom_range(1, 20));
      end
      if ($urandom_range(0, 3) == 0) begin
        clocks_per_bit = 12'($urandom_range(0, 3));
        step(3);
      end
    end
    ackRandomOn = 1'b0;
    step(5);
    pulseAck();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/usart_rx.md
# usart_rx

Asynchronous serial (UART) receiver for the USART library: samples the `rx_pin` line at 16× oversampling and deframes 8N1 characters (LSB first). It presents each byte with an `available` flag until the host acknowledges it, and flags framing and overrun errors. It pairs with the USART transmitter and sits between the external RX pad and the host register interface.

## Interface
- No parameters. The bit rate is runtime-programmable through `clocks_per_bit`.
- `comm_clock` input 1: sole clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `clocks_per_bit` input 12: oversample divisor. One sample tick occurs every `clocks_per_bit+1` clocks, so one bit lasts 16×(`clocks_per_bit`+1) clocks. Sampled continuously; change it only while the receiver is idle.
- `rx_pin` input 1: serial line. Idle high, asynchronous to `comm_clock`.
- `data_out` output 8: last received byte.
- `available` output 1: a byte is waiting in `data_out`.
- `error` output 1: framing or overrun error. Sticky.
- `acknowledge` input 1: host consumed the byte. Level-sampled each clock.

## Operation
- `rx_pin` passes through a 2-flop synchronizer. All decisions use the synchronized value `rxs`.
- The tick prescaler counts 0..`clocks_per_bit` and pulses `tick` on wrap. It is held at 0 in IDLE, so phase aligns to the start edge.
- **IDLE**: on `rxs`=0, go to START and clear the tick counter `tcnt`.
- **START**: after 8 ticks (mid start bit), resample.
  - If `rxs`=1, the start was false: return to IDLE.
  - Otherwise go to DATA with bit index 0 and `tcnt`=0.
- **DATA**: every 16 ticks (mid bit), shift `rxs` into the shift register LSB-first. After bit 7, go to STOP.
- **STOP**: after 16 ticks, sample the stop bit.
  - Load `data_out` from the shift register and set `available`=1.
  - If `available` was already 1 and `acknowledge` is not asserted this cycle, set `error` (overrun); the new byte overwrites `data_out`.
  - If the stop bit is 1, go to IDLE. If it is 0, set `error` (framing) and go to WAIT_IDLE.
- **WAIT_IDLE**: stay until `rxs`=1, then go to IDLE. A held-low line (break) produces exactly one byte and one error.
- `acknowledge`=1 clears `available` and `error` on the next edge. It has no effect when neither is set.
- If `acknowledge` and byte completion occur in the same cycle, completion wins: `available` stays 1, `data_out` takes the new byte, and `error` reflects only the new frame.
- `reset` asserted at any time returns the block to IDLE and clears the prescaler, counters and shift register. Reset values: `data_out`=8'h00, `available`=0, `error`=0. A frame in progress is discarded.

## Timing
- Let D = `clocks_per_bit`+1. Sampling points relative to the synchronized start edge:
  - start check at 8·D clocks;
  - data bit n at (8+16·(n+1))·D clocks;
  - stop bit at 152·D clocks.
- `available`/`data_out`/`error` update on the edge of the stop sample, about 9.5 bit times plus 2–3 sync clocks after the line falls.
- Minimum D is 1 (`clocks_per_bit`=0, 16 clocks per bit).
- Back-to-back frames are supported: a new start bit may follow immediately after the mid-stop sample.

## Structure
- Shared package `usart_pkg` holds:
  - state enum {IDLE, START, DATA, STOP, WAIT_IDLE};
  - `OVERSAMPLE`=16;
  - `DIV_WIDTH`=12;
  - `DATA_BITS`=8.
- One sub-module, `usart_baud_tick`: the divisor counter with synchronous clear, producing the 1-clock `tick`. It is reused by the transmitter.
- The 2-flop synchronizer is inline.

## Test plan
- Reset: assert `reset` low mid-frame → outputs 0/0/0. After release, the next valid frame is received correctly.
- `clocks_per_bit`=1 (32 clocks/bit), send bits 1,0,1,0,1,1,1,0 with stop=1 → `data_out`=8'h75, `available`=1, `error`=0. Pulse `acknowledge` → `available`=0.
- Same rate, bits 1,0,1,0,1,1,1,1, then hold the line low → `data_out`=8'hF5, `available`=1, `error`=1. No second byte while low. After the line returns high and `acknowledge` is pulsed, both flags clear.
- Low glitch of 4·D clocks while idle → rejected as false start; `available` stays 0.
- Two frames 8'h55 then 8'hA3 with no acknowledge → `data_out`=8'hA3, `available`=1, `error`=1 (overrun).
- `acknowledge` held high in the completion cycle of a frame → `available` remains 1 with the new byte and `error`=0. `clocks_per_bit`=0 frame 8'h00 → received correctly at 16 clocks/bit.
